uart_rx_cfg: RTL and testbench

Parametrised UART receiver for the controller's host command path. It generalises the fixed 8N1 receiver with:
- configurable clock/baud, data width, parity and stop bits;
- 3-sample majority voting and false-start rejection;
- parity and framing error reporting.

It sits between the board RS232 pin and the command decoder that feeds the SDRAM write/read FIFOs.

---
 rtl/uart_rx_cfg_if.sv | 30 +++
 rtl/uart_rx_cfg.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line in, received word and status out.
// The receiver takes the slave side; the line driver and consumer take master.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rs232_rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 po_flag;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output rs232_rx,
    input  rx_data,
    input  po_flag,
    input  parity_err,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rs232_rx,
    output rx_data,
    output po_flag,
    output parity_err,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with 3-sample majority voting,
// false-start rejection, parity and framing error reporting.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic sclk,
  input  logic s_rst_n,
  uart_rx_cfg_if.slave bus
);

  localparam int BAUD_END = CLK_FREQ / BAUD - 1;
  localparam int BAUD_M   = BAUD_END / 2;
  localparam int CW       = $clog2(BAUD_END + 1);
  localparam int BW       = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] C_END = CW'(BAUD_END);
  localparam logic [CW-1:0] C_SM1 = CW'(BAUD_M - 1);
  localparam logic [CW-1:0] C_SM  = CW'(BAUD_M);
  localparam logic [CW-1:0] C_SP1 = CW'(BAUD_M + 1);

  localparam logic [BW-1:0] B_DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_SLAST = BW'(STOP_BITS - 1);

  localparam logic P_EN  = (PARITY_EN != 0);
  localparam logic P_ODD = (PARITY_ODD != 0);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (BAUD_END < 3) begin : g_bad_baud
    $error("uart_rx_cfg: CLK_FREQ/BAUD must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic rx_r1;
  logic rx_r2;
  logic rx_r3;
  logic fall;

  logic [CW-1:0] baud_cnt;
  logic [BW-1:0] bit_cnt;

  logic smp0;
  logic smp1;
  logic maj;
  logic decide;
  logic bit_end;
  logic last_stop;

  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr_lat;

  logic [DATA_BITS-1:0] word;
  logic                 flag;
  logic                 perr;
  logic                 ferr;

  assign fall = ~rx_r2 & rx_r3;

  assign decide  = (state != IDLE) && (baud_cnt == C_SP1);
  assign bit_end = (state != IDLE) && (baud_cnt == C_END);

  // third sample is the live rx_r2 at the decision count
  assign maj = (smp0 & smp1) | (smp0 & rx_r2) | (smp1 & rx_r2);

  assign last_stop = (state == STOP) && decide &&
                     (bit_cnt == B_SLAST);

  // three-flop synchroniser, idles high like the line
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rx_r1 <= 1'b1;
      rx_r2 <= 1'b1;
      rx_r3 <= 1'b1;
    end else begin
      rx_r1 <= bus.rs232_rx;
      rx_r2 <= rx_r1;
      rx_r3 <= rx_r2;
    end
  end

  // state register
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state; the last stop bit exits early to catch a back-to-back start
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
        end
      end
      START: begin
        if (decide && maj) begin
          state_nxt = IDLE;
        end else if (bit_end) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_end && (bit_cnt == B_DLAST)) begin
          state_nxt = P_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (last_stop) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // bit-period counter, parked at zero whenever idle or about to idle
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      baud_cnt <= '0;
    end else if (state == IDLE || state_nxt == IDLE) begin
      baud_cnt <= '0;
    end else if (baud_cnt == C_END) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // first two of the three centre samples
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      smp0 <= 1'b1;
      smp1 <= 1'b1;
    end else if (state != IDLE) begin
      if (baud_cnt == C_SM1) begin
        smp0 <= rx_r2;
      end
      if (baud_cnt == C_SM) begin
        smp1 <= rx_r2;
      end
    end
  end

  // bit index within the data or stop field
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      bit_cnt <= '0;
    end else if (state_nxt != state) begin
      bit_cnt <= '0;
    end else if (bit_end && (state == DATA || state == STOP)) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // data shift (first bit lands in bit 0), parity capture, stop errors
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_lat <= 1'b0;
    end else begin
      if (state == DATA && decide) begin
        shreg <= {maj, shreg[DATA_BITS-1:1]};
      end
      if (state == PARITY && decide) begin
        par_bit <= maj;
      end
      if (state == IDLE) begin
        ferr_lat <= 1'b0;
      end else if (state == STOP && decide && !maj) begin
        ferr_lat <= 1'b1;
      end
    end
  end

  // result registers; errors only ever accompany the flag
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      word <= '0;
      flag <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      flag <= last_stop;
      perr <= last_stop & P_EN & ((^shreg ^ par_bit) != P_ODD);
      ferr <= last_stop & (ferr_lat | ~maj);
      if (last_stop) begin
        word <= shreg;
      end
    end
  end

  assign bus.rx_data    = word;
  assign bus.po_flag    = flag;
  assign bus.parity_err = perr;
  assign bus.frame_err  = ferr;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: four receiver configurations driven from one clock,
// checked by vector table, hand sequences and a random frame model.
module tb_uart_rx_cfg;

  localparam int CF = 20;
  localparam int BD = 1;
  localparam int P  = CF / BD;
  localparam int BM = (P - 1) / 2;

  logic sclk = 1'b0;
  logic s_rst_n = 1'b0;
  logic line [4];

  always #5 sclk = ~sclk;

  uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_b ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_c ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if_d ();

  assign if_a.rs232_rx = line[0];
  assign if_b.rs232_rx = line[1];
  assign if_c.rs232_rx = line[2];
  assign if_d.rs232_rx = line[3];

  uart_rx_cfg #(
    .CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_a (.sclk(sclk), .s_rst_n(s_rst_n), .bus(if_a));

  uart_rx_cfg #(
    .CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut_b (.sclk(sclk), .s_rst_n(s_rst_n), .bus(if_b));

  uart_rx_cfg #(
    .CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
  ) dut_c (.sclk(sclk), .s_rst_n(s_rst_n), .bus(if_c));

  uart_rx_cfg #(
    .CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(7),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)
  ) dut_d (.sclk(sclk), .s_rst_n(s_rst_n), .bus(if_d));

  int cdb [4] = '{8, 8, 8, 7};
  int cpe [4] = '{0, 1, 1, 0};
  int cpo [4] = '{0, 0, 1, 0};
  int csb [4] = '{1, 1, 1, 2};

  typedef struct {
    int         sel;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } ev_t;

  typedef struct {
    int         sel;
    logic [8:0] data;
    logic       par;
    logic [1:0] stop;
    logic [8:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  ev_t evq[$];
  int  cyc = 0;
  int  start_cyc = 0;
  int  hold_bad = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge sclk) cyc <= cyc + 1;

  function automatic ev_t mk(int s, logic [8:0] d, logic pe, logic fe, int c);
    ev_t e;
    e.sel = s;
    e.d = d;
    e.pe = pe;
    e.fe = fe;
    e.cyc = c;
    return e;
  endfunction

  always @(posedge sclk) begin
    #1;
    if (if_a.po_flag) evq.push_back(mk(0, {1'b0, if_a.rx_data}, if_a.parity_err, if_a.frame_err, cyc));
    if (if_b.po_flag) evq.push_back(mk(1, {1'b0, if_b.rx_data}, if_b.parity_err, if_b.frame_err, cyc));
    if (if_c.po_flag) evq.push_back(mk(2, {1'b0, if_c.rx_data}, if_c.parity_err, if_c.frame_err, cyc));
    if (if_d.po_flag) evq.push_back(mk(3, {2'b0, if_d.rx_data}, if_d.parity_err, if_d.frame_err, cyc));
    if (!if_a.po_flag && (if_a.parity_err || if_a.frame_err)) hold_bad++;
    if (!if_b.po_flag && (if_b.parity_err || if_b.frame_err)) hold_bad++;
    if (!if_c.po_flag && (if_c.parity_err || if_c.frame_err)) hold_bad++;
    if (!if_d.po_flag && (if_d.parity_err || if_d.frame_err)) hold_bad++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: frame outcome from the field rules, by counting ones
  function automatic ev_t model(int sel, logic [8:0] data, logic par, logic [1:0] stop);
    ev_t e;
    int ones;
    ones = 0;
    e.sel = sel;
    e.d = data & ((9'd1 << cdb[sel]) - 9'd1);
    for (int i = 0; i < cdb[sel]; i++) ones += int'(e.d[i]);
    e.pe = (cpe[sel] != 0) && (((ones + int'(par)) % 2) != cpo[sel]);
    e.fe = 1'b0;
    for (int i = 0; i < csb[sel]; i++) if (!stop[i]) e.fe = 1'b1;
    e.cyc = 0;
    return e;
  endfunction

  task automatic build(input int sel, input logic [8:0] data, input logic par,
                       input logic [1:0] stop, output logic [15:0] bits, output int n);
    bits = '1;
    n = 0;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < cdb[sel]; i++) begin
      bits[n] = data[i];
      n++;
    end
    if (cpe[sel] != 0) begin
      bits[n] = par;
      n++;
    end
    for (int i = 0; i < csb[sel]; i++) begin
      bits[n] = stop[i];
      n++;
    end
  endtask

  // called at a negedge; spike[i] flips one clock near the centre of bit i
  task automatic drive(input int sel, input logic [15:0] bits, input int n, input logic [15:0] spike);
    for (int i = 0; i < n; i++) begin
      if (i == 0) start_cyc = cyc + 1;
      line[sel] = bits[i];
      if (spike[i]) begin
        repeat (BM + 1) @(negedge sclk);
        line[sel] = ~bits[i];
        @(negedge sclk);
        line[sel] = bits[i];
        repeat (P - BM - 2) @(negedge sclk);
      end else begin
        repeat (P) @(negedge sclk);
      end
    end
  endtask

  task automatic idle(input int sel, input int k);
    line[sel] = 1'b1;
    repeat (k) @(negedge sclk);
  endtask

  task automatic send(input int sel, input logic [8:0] data, input logic par, input logic [1:0] stop);
    logic [15:0] bits;
    int n;
    build(sel, data, par, stop, bits, n);
    drive(sel, bits, n, 16'h0000);
    idle(sel, 2 * P);
  endtask

  task automatic expect_one(input string tag, input int sel, input logic [8:0] ed,
                            input logic epe, input logic efe);
    ev_t e;
    chk($sformatf("%s.count", tag), evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk($sformatf("%s.sel", tag), e.sel, sel);
      chk($sformatf("%s.data", tag), int'(e.d), int'(ed));
      chk($sformatf("%s.parity_err", tag), int'(e.pe), int'(epe));
      chk($sformatf("%s.frame_err", tag), int'(e.fe), int'(efe));
    end
    evq.delete();
  endtask

  vec_t vt [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int n;
    int lat;
    int fa;
    ev_t e;
    ev_t ex;
    logic [8:0] rd;
    logic rp;
    logic [1:0] rs;
    int rsel;

    vt[0] = '{0, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};
    vt[1] = '{0, 9'h0A3, 1'b0, 2'b11, 9'h0A3, 1'b0, 1'b0};
    vt[2] = '{0, 9'h00F, 1'b0, 2'b00, 9'h00F, 1'b0, 1'b1};
    vt[3] = '{1, 9'h007, 1'b1, 2'b11, 9'h007, 1'b0, 1'b0};
    vt[4] = '{1, 9'h007, 1'b0, 2'b11, 9'h007, 1'b1, 1'b0};
    vt[5] = '{2, 9'h007, 1'b1, 2'b11, 9'h007, 1'b1, 1'b0};
    vt[6] = '{2, 9'h007, 1'b0, 2'b11, 9'h007, 1'b0, 1'b0};
    vt[7] = '{3, 9'h07F, 1'b0, 2'b11, 9'h07F, 1'b0, 1'b0};
    vt[8] = '{3, 9'h02A, 1'b0, 2'b01, 9'h02A, 1'b0, 1'b1};
    vt[9] = '{1, 9'h000, 1'b0, 2'b00, 9'h000, 1'b0, 1'b1};

    for (int i = 0; i < 4; i++) line[i] = 1'b1;
    s_rst_n = 1'b0;
    repeat (3) @(negedge sclk);
    chk("rst.a.data", int'(if_a.rx_data), 0);
    chk("rst.a.flag", int'(if_a.po_flag), 0);
    chk("rst.a.busy", int'(if_a.busy), 0);
    chk("rst.d.errs", int'({if_d.parity_err, if_d.frame_err}), 0);
    s_rst_n = 1'b1;
    repeat (2 * P) @(negedge sclk);
    chk("rst.idle_no_pulse", evq.size(), 0);

    // vector table; the first one also measures the edge-to-flag latency
    fa = 9 * P + BM;
    for (int i = 0; i < 10; i++) begin
      build(vt[i].sel, vt[i].data, vt[i].par, vt[i].stop, bits, n);
      drive(vt[i].sel, bits, n, 16'h0000);
      idle(vt[i].sel, 2 * P);
      if (i == 0 && evq.size() > 0) begin
        lat = evq[0].cyc - start_cyc;
        chk("latency.window", int'(lat >= fa + 2 && lat <= fa + 4), 1);
      end
      expect_one($sformatf("vec%0d", i), vt[i].sel, vt[i].ed, vt[i].epe, vt[i].efe);
    end

    // glitch shorter than the sample window is a false start
    line[0] = 1'b0;
    repeat (4) @(negedge sclk);
    line[0] = 1'b1;
    repeat (3) @(negedge sclk);
    chk("glitch.busy_hi", int'(if_a.busy), 1);
    repeat (P) @(negedge sclk);
    chk("glitch.busy_lo", int'(if_a.busy), 0);
    chk("glitch.no_pulse", evq.size(), 0);
    send(0, 9'h0A3, 1'b0, 2'b11);
    expect_one("glitch.next", 0, 9'h0A3, 1'b0, 1'b0);

    // break: one errored frame, then silence until the line recovers
    line[0] = 1'b0;
    repeat (12 * P) @(negedge sclk);
    chk("break.busy_lo", int'(if_a.busy), 0);
    idle(0, 2 * P);
    expect_one("break", 0, 9'h000, 1'b0, 1'b1);
    send(0, 9'h03C, 1'b0, 2'b11);
    expect_one("break.next", 0, 9'h03C, 1'b0, 1'b0);

    // back-to-back 7-bit, two stop bits; low second stop on the last frame
    build(3, 9'h07F, 1'b0, 2'b11, bits, n);
    drive(3, bits, n, 16'h0000);
    build(3, 9'h000, 1'b0, 2'b11, bits, n);
    drive(3, bits, n, 16'h0000);
    build(3, 9'h02A, 1'b0, 2'b01, bits, n);
    drive(3, bits, n, 16'h0000);
    idle(3, 2 * P);
    chk("b2b.count", evq.size(), 3);
    if (evq.size() == 3) begin
      e = evq.pop_front();
      chk("b2b0.data", int'(e.d), 'h7F);
      chk("b2b0.fe", int'(e.fe), 0);
      e = evq.pop_front();
      chk("b2b1.data", int'(e.d), 'h00);
      chk("b2b1.fe", int'(e.fe), 0);
      e = evq.pop_front();
      chk("b2b2.data", int'(e.d), 'h2A);
      chk("b2b2.fe", int'(e.fe), 1);
    end
    evq.delete();

    // single-clock low spikes in every data bit centre
    build(0, 9'h0FF, 1'b0, 2'b11, bits, n);
    drive(0, bits, n, 16'h01FE);
    idle(0, 2 * P);
    expect_one("spike", 0, 9'h0FF, 1'b0, 1'b0);

    // reset part-way through the data field
    build(0, 9'h096, 1'b0, 2'b11, bits, n);
    drive(0, bits, 4, 16'h0000);
    s_rst_n = 1'b0;
    #1;
    chk("midrst.data", int'(if_a.rx_data), 0);
    chk("midrst.busy", int'(if_a.busy), 0);
    chk("midrst.flag", int'(if_a.po_flag), 0);
    line[0] = 1'b1;
    repeat (P) @(negedge sclk);
    s_rst_n = 1'b1;
    repeat (2 * P) @(negedge sclk);
    chk("midrst.no_pulse", evq.size(), 0);
    evq.delete();
    send(0, 9'h096, 1'b0, 2'b11);
    expect_one("midrst.next", 0, 9'h096, 1'b0, 1'b0);

    // random frames against the field-rule model
    for (int k = 0; k < 48; k++) begin
      rsel = int'($urandom_range(0, 3));
      rd = 9'($urandom);
      rp = 1'($urandom);
      rs[0] = ($urandom_range(0, 7) != 0);
      rs[1] = ($urandom_range(0, 7) != 0);
      ex = model(rsel, rd, rp, rs);
      send(rsel, rd, rp, rs);
      expect_one($sformatf("rnd%0d", k), rsel, ex.d, ex.pe, ex.fe);
    end

    chk("hold.errs_without_flag", hold_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
